mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit owning the MIPS HI/LO registers. It sits beside the combinational ALU in EX.
//  It runs MULT/MULTU/DIV/DIVU over multiple cycles with a start/busy/done handshake, and also executes MTHI/MTLO.
//  The pipeline stalls on busy and reads hi/lo for MFHI/MFLO.
// PARAMETERS
//  WIDTH   32  operand width; hi and lo are each WIDTH bits; WIDTH must be even and >= 4
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only when busy=0
//  op     in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//  a      in   WIDTH  operand A (dividend / multiplicand / MTxx source)
//  b      in   WIDTH  operand B (divisor / multiplier)
//  busy   out  1      iterative operation in flight; start ignored
//  done   out  1      one-cycle pulse; hi/lo hold the new result this cycle
//  hi     out  WIDTH  HI register (product upper half / remainder)
//  lo     out  WIDTH  LO register (product lower half / quotient)
//  div0   out  1      pulses with done when a DIV/DIVU had b==0
// BEHAVIOUR
//  - Reset: busy=0, done=0, div0=0, hi=0, lo=0, FSM=IDLE. A reset mid-operation aborts the operation and discards its result.
//  - FSM states are IDLE, CALC, FIX.
//    - IDLE -> CALC: start=1 with op 0-3 (a and b latched). busy=1 from the next cycle.
//    - CALC: runs WIDTH cycles, one bit per cycle. MULT: shift-add on magnitudes. DIV: restoring on magnitudes.
//    - CALC -> FIX: after the WIDTH-th step. FIX applies sign correction and writes hi/lo.
//    - FIX -> IDLE: done=1, busy=0 in the first IDLE cycle.
//    - Latency: done asserts WIDTH+2 cycles after the start edge (34 for WIDTH=32).
//  - A new start is accepted in the same cycle done=1 (back-to-back operation).
//  - hi/lo keep their old values until FIX writes them. done and div0 are registered pulses.
//  - Signed rules:
//    - MULT: 2W-bit product is negated when a[W-1]^b[W-1].
//    - DIV: quotient sign is a^b; remainder takes the sign of a.
//    - MIN/-1 gives lo=MIN, hi=0, with no flag.
//  - b==0 on DIV/DIVU: hi=a, lo=all ones, div0=1. Total latency is unchanged.
//  - MTHI/MTLO: hi (resp. lo) <= a at the start edge; done=1 the next cycle; busy never set.
//  - Reserved op: no register change; done=1 the next cycle.
//  - start while busy=1 is ignored, with no side effect on the running operation.
// CONFIGURATION
//  - MDU_FAST_MUL_EN defined:
//    - MULT/MULTU use a single-cycle combinational WIDTH x WIDTH multiply.
//    - hi/lo are written at the start edge; done=1 the next cycle; busy never set.
//    - DIV is unchanged.
//  - MDU_FAST_MUL_EN undefined: MULT/MULTU are iterative, as specified above.
// STRUCTURE
//  - Package mdu_pkg: op encodings (MDU_MULT..MDU_MTLO), FSM state encoding, iteration-counter width $clog2(WIDTH)+1.
//  - Sub-module mdu_step: one combinational iteration, i.e. the add/subtract-and-shift on the {acc,q} pair, selected by mult/div.
//    The top level holds the FSM, counter, operand and sign registers, and hi/lo.
// TESTING (WIDTH=32)
//  1. MULT a=20 b=5 -> done at +34 cycles; hi=00000000 lo=00000064; busy high for cycles 1..33.
//  2. MULT a=FFFFFFEC b=1 -> hi=FFFFFFFF lo=FFFFFFEC. MULTU with the same operands -> hi=00000000 lo=FFFFFFEC.
//  3. DIV a=FFFFFFEC(-20) b=3 -> lo=FFFFFFFA(-6) hi=FFFFFFFE(-2). DIVU a=20 b=3 -> lo=6 hi=2.
//  4. DIVU a=20 b=0 -> div0=1 with done; hi=00000014 lo=FFFFFFFF. DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//  5. MTHI a=DEADBEEF, then MTLO a=12345678 -> done after 1 cycle each; busy stays 0.
//     Then start MULT, pulse start again at +5 cycles with op=MTHI -> ignored; hi/lo hold the MULT result only.
//  6. rst=1 at cycle 10 of a DIV -> next cycle busy=0 hi=lo=0; no done.
//     A following MULT 7*6 gives lo=0000002A. Repeat tests 1-2 with MDU_FAST_MUL_EN: done at +1 cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module  : mdu_pkg
// Purpose : Shared op encodings, FSM states and counter sizing for mul_div_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

   function automatic int mdu_cnt_w(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
// ============================================================================
// Module  : mdu_step
// Purpose : One combinational iteration on the {acc,q} pair: shift-add for
//           multiply (LSB first) or restoring subtract-shift for divide.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] m_in,
   output logic [WIDTH-1:0] acc_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   always_comb begin
      sum     = {1'b0, acc_in} + (q_in[0] ? {1'b0, m_in} : '0);
      shifted = {acc_in, q_in[WIDTH-1]};
      fits    = (shifted >= {1'b0, m_in});
      // Remainder after a successful subtract is < m, so W bits suffice.
      diff    = shifted[WIDTH-1:0] - m_in;

      acc_out = sum[WIDTH:1];
      q_out   = {sum[0], q_in[WIDTH-1:1]};
      if (is_div) begin
         if (fits) begin
            acc_out = diff;
            q_out   = {q_in[WIDTH-2:0], 1'b1};
         end else begin
            acc_out = shifted[WIDTH-1:0];
            q_out   = {q_in[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module  : mul_div_unit
// Purpose : Iterative MIPS multiply/divide unit owning HI/LO, with MTHI/MTLO.
//           Define MDU_FAST_MUL_EN for single-cycle combinational MULT/MULTU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div0
);

   localparam int              CNT_W     = mdu_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;
   logic             neg_rem_q, neg_rem_d;
   logic             bzero_q, bzero_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             div0_q, div0_d;

   logic             ld_signed;
   logic             ld_a_neg;
   logic             ld_b_neg;
   logic [WIDTH-1:0] ld_a_mag;
   logic [WIDTH-1:0] ld_b_mag;
   logic [WIDTH-1:0] step_acc;
   logic [WIDTH-1:0] step_q;
   logic [2*WIDTH-1:0] prod_res;
   logic [WIDTH-1:0] quot_res;
   logic [WIDTH-1:0] rem_res;

`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod_s;
   logic [2*WIDTH-1:0] fast_prod_u;

   always_comb begin
      fast_prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      fast_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   end
`endif

   mdu_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div  (is_div_q),
      .acc_in  (acc_q),
      .q_in    (quo_q),
      .m_in    (m_q),
      .acc_out (step_acc),
      .q_out   (step_q)
   );

   // Operand conditioning: the core always works on magnitudes.
   always_comb begin
      ld_signed = (op == MDU_MULT) || (op == MDU_DIV);
      ld_a_neg  = ld_signed & a[WIDTH-1];
      ld_b_neg  = ld_signed & b[WIDTH-1];
      ld_a_mag  = ld_a_neg ? -a : a;
      ld_b_mag  = ld_b_neg ? -b : b;
   end

   always_comb begin
      prod_res = neg_q ? -{acc_q, quo_q} : {acc_q, quo_q};
      quot_res = neg_q ? -quo_q : quo_q;
      rem_res  = neg_rem_q ? -acc_q : acc_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      quo_d     = quo_q;
      m_d       = m_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      bzero_d   = bzero_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      div0_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
`ifdef MDU_FAST_MUL_EN
                  MDU_MULT: begin
                     {hi_d, lo_d} = fast_prod_s;
                     done_d       = 1'b1;
                  end
                  MDU_MULTU: begin
                     {hi_d, lo_d} = fast_prod_u;
                     done_d       = 1'b1;
                  end
                  MDU_DIV, MDU_DIVU: begin
`else
                  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
`endif
                     is_div_d  = op[1];
                     quo_d     = op[1] ? ld_a_mag : ld_b_mag;
                     m_d       = op[1] ? ld_b_mag : ld_a_mag;
                     acc_d     = '0;
                     cnt_d     = '0;
                     neg_d     = ld_a_neg ^ ld_b_neg;
                     neg_rem_d = ld_a_neg;
                     bzero_d   = (b == '0);
                     state_d   = ST_CALC;
                  end
                  MDU_MTHI: begin
                     hi_d   = a;
                     done_d = 1'b1;
                  end
                  MDU_MTLO: begin
                     lo_d   = a;
                     done_d = 1'b1;
                  end
                  default: done_d = 1'b1;
               endcase
            end
         end
         ST_CALC: begin
            acc_d = step_acc;
            quo_d = step_q;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            // Divide-by-zero leaves remainder = a after sign fix; only lo is forced.
            if (is_div_q) begin
               hi_d   = rem_res;
               lo_d   = bzero_q ? '1 : quot_res;
               div0_d = bzero_q;
            end else begin
               {hi_d, lo_d} = prod_res;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         quo_q     <= '0;
         m_q       <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         bzero_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         quo_q     <= quo_d;
         m_q       <= m_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         bzero_q   <= bzero_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         div0_q    <= div0_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign div0 = div0_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module  : tb_mul_div_unit
// Purpose : Scoreboard bench for mul_div_unit (WIDTH=32), directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

   localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT  = 1;
   localparam bit MUL_ITER = 1'b0;
`else
   localparam int MUL_LAT  = W + 2;
   localparam bit MUL_ITER = 1'b1;
`endif
   localparam int DIV_LAT = W + 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         div0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .div0  (div0)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         div0;
      int           issue;
      int           lat;
   } exp_t;

   exp_t         sbq[$];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] mhi = '0;
   logic [W-1:0] mlo = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && done) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
         end else begin
            e = sbq.pop_front();
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
            chk("div0", 64'(div0), 64'(e.div0));
            chk("latency", 64'(cyc - e.issue), 64'(e.lat));
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                        input int lat, input bit now);
      if (!now) @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = av;
      b     = bv;
      sbq.push_back('{hi: eh, lo: el, div0: ed, issue: cyc, lat: lat});
      mhi = eh;
      mlo = el;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input bit iter);
      int n;
      n = 0;
      while (!done && n < 100) begin
         if (iter) chk("busy_running", 64'(busy), 64'd1);
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done in %0d cycles expected done", n);
         sbq.delete();
      end else begin
         chk("busy_at_done", 64'(busy), 64'd0);
      end
   endtask

   initial begin : stim
      logic seen;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_div0", 64'(div0), 64'd0);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);

      // Multiply, signed and unsigned
      issue(3'd0, 32'd20, 32'd5, 32'h0, 32'h64, 1'b0, MUL_LAT, 1'b0);             wait_done(MUL_ITER);
      issue(3'd0, 32'hFFFFFFEC, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b0, MUL_LAT, 1'b0); wait_done(MUL_ITER);
      issue(3'd1, 32'hFFFFFFEC, 32'd1, 32'h0, 32'hFFFFFFEC, 1'b0, MUL_LAT, 1'b0);  wait_done(MUL_ITER);
      issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, MUL_LAT, 1'b0);  wait_done(MUL_ITER);
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0, MUL_LAT, 1'b0); wait_done(MUL_ITER);

      // Divide, signs and edge cases
      issue(3'd2, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFA, 1'b0, DIV_LAT, 1'b0); wait_done(1'b1);
      issue(3'd3, 32'd20, 32'd3, 32'd2, 32'd6, 1'b0, DIV_LAT, 1'b0);                wait_done(1'b1);
      issue(3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, DIV_LAT, 1'b0);  wait_done(1'b1);
      issue(3'd3, 32'd20, 32'd0, 32'h14, 32'hFFFFFFFF, 1'b1, DIV_LAT, 1'b0);        wait_done(1'b1);
      issue(3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, DIV_LAT, 1'b0); wait_done(1'b1);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, DIV_LAT, 1'b0); wait_done(1'b1);

      // Moves and reserved op
      issue(3'd4, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, mlo, 1'b0, 1, 1'b0);          wait_done(1'b0);
      issue(3'd5, 32'h12345678, 32'd0, mhi, 32'h12345678, 1'b0, 1, 1'b0);          wait_done(1'b0);
      issue(3'd6, 32'h11111111, 32'h22222222, mhi, mlo, 1'b0, 1, 1'b0);            wait_done(1'b0);

      // Start while busy must be ignored
`ifdef MDU_FAST_MUL_EN
      issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT, 1'b0);
`else
      issue(3'd0, 32'd20, 32'd5, 32'h0, 32'h64, 1'b0, MUL_LAT, 1'b0);
`endif
      repeat (3) @(negedge clk);
      chk("busy_before_ignored_start", 64'(busy), 64'd1);
      start = 1'b1;
      op    = 3'd4;
      a     = 32'h55555555;
      @(negedge clk);
      start = 1'b0;
      wait_done(1'b1);

      // Back-to-back: next op starts in the done cycle
      issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT, 1'b1);             wait_done(1'b1);
      issue(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, MUL_LAT, 1'b1);               wait_done(MUL_ITER);

      // Reset mid-divide discards the result
      issue(3'd2, 32'd1000, 32'd9, 32'd1, 32'd111, 1'b0, DIV_LAT, 1'b0);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      sbq.delete();
      mhi = '0;
      mlo = '0;
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_hi", 64'(hi), 64'd0);
      chk("midrst_lo", 64'(lo), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | done;
      end
      chk("no_done_after_rst", 64'(seen), 64'd0);

      issue(3'd0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, MUL_LAT, 1'b0);               wait_done(MUL_ITER);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
